// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
// Provides the arbiter state encoding, the read-return owner encoding and the
// default sizing parameters used by dmem_arbiter and anything that talks to it.
package dmem_pkg;

   // Default address width; the memory data width is half of this.
   localparam int N_DEF        = 16;
   // Consecutive denied host cycles before the host is forced through.
   localparam int MAX_WAIT_DEF = 8;
   // Width of the host wait counter; must hold MAX_WAIT_DEF.
   localparam int WCNT_W_DEF   = 4;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port, byte-wide, registered-read data memory between the
// processor core (port C) and the host loader/unloader (port H).
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata  core command, held until c_gnt
//   c_gnt/c_rvalid/c_rdata     core grant and read return
//   h_req/h_we/h_addr/h_wdata  host command, held until h_gnt
//   h_lock                     host asks for exclusive ownership
//   h_gnt/h_rvalid/h_rdata     host grant and read return
//   locked                     arbiter is in the LOCKED state
//   mem_write_en/mem_addr/mem_datain  command to the memory
//   mem_dataout                memory read data, one cycle after the read
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int WCNT_W   = WCNT_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           c_req,
   input  logic           c_we,
   input  logic [N-1:0]   c_addr,
   input  logic [N/2-1:0] c_wdata,
   output logic           c_gnt,
   output logic           c_rvalid,
   output logic [N/2-1:0] c_rdata,
   input  logic           h_req,
   input  logic           h_we,
   input  logic [N-1:0]   h_addr,
   input  logic [N/2-1:0] h_wdata,
   input  logic           h_lock,
   output logic           h_gnt,
   output logic           h_rvalid,
   output logic [N/2-1:0] h_rdata,
   output logic           locked,
   output logic           mem_write_en,
   output logic [N-1:0]   mem_addr,
   output logic [N-1:0]   mem_datain,
   input  logic [N/2-1:0] mem_dataout
);

   localparam int DW = N / 2;
   localparam logic [WCNT_W-1:0] MaxWaitCnt = WCNT_W'(MAX_WAIT);

   state_t            r_state;
   state_t            w_nextState;
   logic [WCNT_W-1:0] r_waitCnt;
   logic              w_cGnt;
   logic              w_hGnt;
   logic              w_memWe;
   logic [N-1:0]      w_memAddr;
   logic [N-1:0]      w_memDatain;
   logic [N-1:0]      r_memAddr;
   logic [N-1:0]      r_memDatain;
   logic              r_rdValid;
   owner_t            r_rdOwner;
   logic [DW-1:0]     r_cRdata;
   logic [DW-1:0]     r_hRdata;
   logic              w_cRvalid;
   logic              w_hRvalid;

   // State register: NORMAL out of reset, which also releases any lock.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_NORMAL;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: the lock only takes hold once the host actually owns the
   // port, and it is released on the first cycle h_lock is seen low.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_NORMAL: if (w_hGnt && h_lock) w_nextState = ST_LOCKED;
         ST_LOCKED: if (!h_lock)          w_nextState = ST_NORMAL;
         default:   w_nextState = ST_NORMAL;
      endcase
   end

   // Grant outputs: host wins when the core is idle or the host has waited
   // MAX_WAIT cycles; while locked only the host can be granted. Reset forces
   // both grants low regardless of the requests.
   always_comb begin
      w_cGnt = 1'b0;
      w_hGnt = 1'b0;
      if (rst_n) begin
         if (r_state == ST_LOCKED) begin
            w_hGnt = h_req;
         end else if (h_req && (!c_req || r_waitCnt == MaxWaitCnt)) begin
            w_hGnt = 1'b1;
         end else begin
            w_cGnt = c_req;
         end
      end
   end

   // Host starvation counter: counts consecutive denied host cycles and
   // saturates so the forced host win stays armed until it happens.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_waitCnt <= '0;
      end else if (!h_req || w_hGnt) begin
         r_waitCnt <= '0;
      end else if (r_waitCnt != MaxWaitCnt) begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   // Memory command mux: the granted command goes out in its grant cycle;
   // with no grant the address and data lines keep their last values.
   always_comb begin
      w_memWe     = (w_cGnt && c_we) || (w_hGnt && h_we);
      w_memAddr   = r_memAddr;
      w_memDatain = r_memDatain;
      if (w_hGnt) begin
         w_memAddr   = h_addr;
         w_memDatain = {{(N - DW){1'b0}}, h_wdata};
      end else if (w_cGnt) begin
         w_memAddr   = c_addr;
         w_memDatain = {{(N - DW){1'b0}}, c_wdata};
      end
   end

   // Holding registers behind the memory command lines.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_memAddr   <= '0;
         r_memDatain <= '0;
      end else begin
         r_memAddr   <= w_memAddr;
         r_memDatain <= w_memDatain;
      end
   end

   // Read-return tracking: one valid/owner pair per cycle matches the
   // memory's single cycle of read latency, so alternating owners never
   // collide. Reset drops any return that is in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdValid <= 1'b0;
         r_rdOwner <= OWN_CORE;
      end else begin
         r_rdValid <= (w_cGnt && !c_we) || (w_hGnt && !h_we);
         r_rdOwner <= w_hGnt ? OWN_HOST : OWN_CORE;
      end
   end

   assign w_cRvalid = r_rdValid && (r_rdOwner == OWN_CORE);
   assign w_hRvalid = r_rdValid && (r_rdOwner == OWN_HOST);

   // Read-data hold registers so each port's rdata stays put between returns.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cRdata <= '0;
         r_hRdata <= '0;
      end else begin
         if (w_cRvalid) r_cRdata <= mem_dataout;
         if (w_hRvalid) r_hRdata <= mem_dataout;
      end
   end

   assign c_gnt        = w_cGnt;
   assign h_gnt        = w_hGnt;
   assign c_rvalid     = w_cRvalid;
   assign h_rvalid     = w_hRvalid;
   assign c_rdata      = w_cRvalid ? mem_dataout : r_cRdata;
   assign h_rdata      = w_hRvalid ? mem_dataout : r_hRdata;
   assign locked       = (r_state == ST_LOCKED);
   assign mem_write_en = w_memWe;
   assign mem_addr     = w_memAddr;
   assign mem_datain   = w_memDatain;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter with a behavioural byte-wide registered-read
// memory behind it. Each applyStimulus call is one clock cycle: inputs are
// driven just after the falling edge and outputs are sampled 1 ns later.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        c_req, c_we, h_req, h_we, h_lock;
   logic [15:0] c_addr, h_addr;
   logic [7:0]  c_wdata, h_wdata;
   logic        c_gnt, c_rvalid, h_gnt, h_rvalid, locked, mem_write_en;
   logic [7:0]  c_rdata, h_rdata, mem_dataout;
   logic [15:0] mem_addr, mem_datain;

   logic [7:0]  memArray [0:65535];

   int errorCount = 0;
   int checkCount = 0;

   dmem_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .c_req        (c_req),
      .c_we         (c_we),
      .c_addr       (c_addr),
      .c_wdata      (c_wdata),
      .c_gnt        (c_gnt),
      .c_rvalid     (c_rvalid),
      .c_rdata      (c_rdata),
      .h_req        (h_req),
      .h_we         (h_we),
      .h_addr       (h_addr),
      .h_wdata      (h_wdata),
      .h_lock       (h_lock),
      .h_gnt        (h_gnt),
      .h_rvalid     (h_rvalid),
      .h_rdata      (h_rdata),
      .locked       (locked),
      .mem_write_en (mem_write_en),
      .mem_addr     (mem_addr),
      .mem_datain   (mem_datain),
      .mem_dataout  (mem_dataout)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural data memory: synchronous write, registered read.
   always @(posedge clk) begin
      if (mem_write_en) memArray[mem_addr] <= mem_datain[7:0];
      mem_dataout <= memArray[mem_addr];
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // One cycle of stimulus, sampled 1 ns after the falling edge.
   task automatic applyStimulus(input logic rstN,
                                input logic cReq, input logic cWe,
                                input logic [15:0] cAddr, input logic [7:0] cWdata,
                                input logic hReq, input logic hWe,
                                input logic [15:0] hAddr, input logic [7:0] hWdata,
                                input logic hLock);
      @(negedge clk);
      rst_n   = rstN;
      c_req   = cReq;
      c_we    = cWe;
      c_addr  = cAddr;
      c_wdata = cWdata;
      h_req   = hReq;
      h_we    = hWe;
      h_addr  = hAddr;
      h_wdata = hWdata;
      h_lock  = hLock;
      #1;
   endtask

   // Single comparison point for every check.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_lock = 1'b0;
      memArray[4]  = 8'd1;
      memArray[5]  = 8'd2;
      memArray[68] = 8'd3;

      // Reset with requests active: grants and write enable forced low.
      applyStimulus(0, 1, 0, 16'd4, 8'h00, 1, 1, 16'd100, 8'h55, 1);
      checkOutput("rstCGnt", 32'(c_gnt), 0);
      checkOutput("rstHGnt", 32'(h_gnt), 0);
      checkOutput("rstWe", 32'(mem_write_en), 0);
      applyStimulus(0, 0, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("rstLocked", 32'(locked), 0);
      checkOutput("rstCRvalid", 32'(c_rvalid), 0);
      checkOutput("rstHRvalid", 32'(h_rvalid), 0);
      checkOutput("rstCRdata", 32'(c_rdata), 0);
      checkOutput("rstHRdata", 32'(h_rdata), 0);
      checkOutput("rstAddr", 32'(mem_addr), 0);
      checkOutput("rstDatain", 32'(mem_datain), 0);

      // Core back-to-back reads of 4 and 5.
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("rd4CGnt", 32'(c_gnt), 1);
      checkOutput("rd4HGnt", 32'(h_gnt), 0);
      checkOutput("rd4Addr", 32'(mem_addr), 4);
      checkOutput("rd4We", 32'(mem_write_en), 0);
      applyStimulus(1, 1, 0, 16'd5, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("rd5CGnt", 32'(c_gnt), 1);
      checkOutput("rd4CRvalid", 32'(c_rvalid), 1);
      checkOutput("rd4CRdata", 32'(c_rdata), 1);
      checkOutput("rd4HRvalid", 32'(h_rvalid), 0);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("rd5CRvalid", 32'(c_rvalid), 1);
      checkOutput("rd5CRdata", 32'(c_rdata), 2);
      checkOutput("rd5HRvalid", 32'(h_rvalid), 0);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("idleCRvalid", 32'(c_rvalid), 0);
      checkOutput("holdCRdata", 32'(c_rdata), 2);
      checkOutput("holdAddr", 32'(mem_addr), 5);
      checkOutput("idleWe", 32'(mem_write_en), 0);

      // Host write 0x2A to 100, core reads it back.
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 1, 1, 16'd100, 8'h2A, 0);
      checkOutput("hwrHGnt", 32'(h_gnt), 1);
      checkOutput("hwrCGnt", 32'(c_gnt), 0);
      checkOutput("hwrWe", 32'(mem_write_en), 1);
      checkOutput("hwrDatain", 32'(mem_datain), 32'h002A);
      checkOutput("hwrAddr", 32'(mem_addr), 100);
      applyStimulus(1, 1, 0, 16'd100, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("rd100We", 32'(mem_write_en), 0);
      checkOutput("rd100CGnt", 32'(c_gnt), 1);
      checkOutput("hwrNoRvalid", 32'(h_rvalid), 0);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("rd100CRvalid", 32'(c_rvalid), 1);
      checkOutput("rd100CRdata", 32'(c_rdata), 32'h2A);
      checkOutput("rd100HRvalid", 32'(h_rvalid), 0);

      // Starvation guard: core wins 8 times, host forced through on the 9th.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1, 1, 0, 16'd4, 8'h00, 1, 0, 16'd68, 8'h00, 0);
         checkOutput($sformatf("starveCGnt%0d", i), 32'(c_gnt), 1);
         checkOutput($sformatf("starveHGnt%0d", i), 32'(h_gnt), 0);
      end
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 1, 0, 16'd68, 8'h00, 0);
      checkOutput("forceHGnt", 32'(h_gnt), 1);
      checkOutput("forceCGnt", 32'(c_gnt), 0);
      checkOutput("forceAddr", 32'(mem_addr), 68);
      checkOutput("forceCRvalid", 32'(c_rvalid), 1);
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 1, 0, 16'd68, 8'h00, 0);
      checkOutput("regrantCGnt", 32'(c_gnt), 1);
      checkOutput("regrantHGnt", 32'(h_gnt), 0);
      checkOutput("forceHRvalid", 32'(h_rvalid), 1);
      checkOutput("forceHRdata", 32'(h_rdata), 3);
      checkOutput("forceCNoRvalid", 32'(c_rvalid), 0);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("regrantCRvalid", 32'(c_rvalid), 1);
      checkOutput("regrantCRdata", 32'(c_rdata), 1);
      checkOutput("regrantHRvalid", 32'(h_rvalid), 0);

      // Lock requested while host is denied: no effect.
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 1, 1, 16'd258, 8'h11, 1);
      checkOutput("deniedLockCGnt", 32'(c_gnt), 1);
      checkOutput("deniedLockHGnt", 32'(h_gnt), 0);
      // Host granted with lock: still NORMAL this cycle.
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 1, 1, 16'd258, 8'h11, 1);
      checkOutput("deniedLockLocked", 32'(locked), 0);
      checkOutput("lockHGnt", 32'(h_gnt), 1);
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 1, 1, 16'd259, 8'h22, 1);
      checkOutput("lock259Locked", 32'(locked), 1);
      checkOutput("lock259CGnt", 32'(c_gnt), 0);
      checkOutput("lock259HGnt", 32'(h_gnt), 1);
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 1, 1, 16'd322, 8'h33, 1);
      checkOutput("lock322Locked", 32'(locked), 1);
      checkOutput("lock322CGnt", 32'(c_gnt), 0);
      checkOutput("lock322Datain", 32'(mem_datain), 32'h0033);
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 1, 1, 16'd323, 8'h44, 1);
      checkOutput("lock323Locked", 32'(locked), 1);
      checkOutput("lock323CGnt", 32'(c_gnt), 0);
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("unlockCycleLocked", 32'(locked), 1);
      checkOutput("unlockCycleCGnt", 32'(c_gnt), 0);
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("unlockedLocked", 32'(locked), 0);
      checkOutput("unlockedCGnt", 32'(c_gnt), 1);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 1, 0, 16'd322, 8'h00, 0);
      checkOutput("rd322HGnt", 32'(h_gnt), 1);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("rd322HRvalid", 32'(h_rvalid), 1);
      checkOutput("rd322HRdata", 32'(h_rdata), 32'h33);

      // Alternating owners, no bubbles.
      applyStimulus(1, 1, 0, 16'd4, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("altC4Gnt", 32'(c_gnt), 1);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 1, 0, 16'd68, 8'h00, 0);
      checkOutput("altH68Gnt", 32'(h_gnt), 1);
      checkOutput("altCRvalid", 32'(c_rvalid), 1);
      checkOutput("altCRdata", 32'(c_rdata), 1);
      checkOutput("altHNoRvalid", 32'(h_rvalid), 0);
      applyStimulus(1, 1, 0, 16'd5, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("altHRvalid", 32'(h_rvalid), 1);
      checkOutput("altHRdata", 32'(h_rdata), 3);
      checkOutput("altCNoRvalid", 32'(c_rvalid), 0);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("alt2CRvalid", 32'(c_rvalid), 1);
      checkOutput("alt2CRdata", 32'(c_rdata), 2);
      checkOutput("alt2HHold", 32'(h_rdata), 3);

      // Reset while locked with a read return in flight.
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 1, 0, 16'd68, 8'h00, 1);
      checkOutput("rlHGnt", 32'(h_gnt), 1);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 1, 0, 16'd4, 8'h00, 1);
      checkOutput("rlLocked", 32'(locked), 1);
      checkOutput("rlHGnt2", 32'(h_gnt), 1);
      applyStimulus(0, 1, 0, 16'd5, 8'h00, 1, 0, 16'd5, 8'h00, 1);
      checkOutput("rlRstHGnt", 32'(h_gnt), 0);
      checkOutput("rlRstCGnt", 32'(c_gnt), 0);
      checkOutput("rlRstWe", 32'(mem_write_en), 0);
      applyStimulus(1, 1, 0, 16'd5, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("postRstLocked", 32'(locked), 0);
      checkOutput("postRstHRvalid", 32'(h_rvalid), 0);
      checkOutput("postRstCRvalid", 32'(c_rvalid), 0);
      checkOutput("postRstHRdata", 32'(h_rdata), 0);
      checkOutput("postRstCRdata", 32'(c_rdata), 0);
      checkOutput("postRstCGnt", 32'(c_gnt), 1);
      applyStimulus(1, 0, 0, 16'd0, 8'h00, 0, 0, 16'd0, 8'h00, 0);
      checkOutput("postRstRdCRvalid", 32'(c_rvalid), 1);
      checkOutput("postRstRdCRdata", 32'(c_rdata), 2);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
